// File: rtl/kan_pkg.sv
// kan_pkg: shared definitions for the KAN layer sequencer and its helpers.
//   - AXI AR-channel constants for 64-bit INCR bursts
//   - per-layer descriptor record (weight base address, input/output sizes)
//   - sequencer state encoding
//   - desc_beats(): number of 64-bit weight beats a descriptor needs
package kan_pkg;

  localparam int KAN_LG_LAYERSIZE = 12;
  localparam int KAN_ADDR_WIDTH   = 32;
  localparam int KAN_BEATS_W      = 2 * KAN_LG_LAYERSIZE;

  localparam logic [2:0] ARSIZE_64B   = 3'b011;
  localparam logic [1:0] ARBURST_INCR = 2'b01;

  typedef struct packed {
    logic [KAN_ADDR_WIDTH-1:0]   base;
    logic [KAN_LG_LAYERSIZE-1:0] in_x5;
    logic [KAN_LG_LAYERSIZE-1:0] out;
  } kan_desc_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_NEXT  = 3'd4
  } kan_state_t;

  // Weight beats for one layer: full-width product so no size pair overflows.
  function automatic logic [KAN_BEATS_W-1:0] desc_beats(input kan_desc_t d);
    return KAN_BEATS_W'(d.in_x5) * KAN_BEATS_W'(d.out);
  endfunction

endpackage

// File: rtl/kan_burst_splitter.sv
// kan_burst_splitter: combinational AXI burst sizing for 64-bit beats.
//   Picks len = min(MAX_BURST, beats_left, beats to next 4 KB boundary) and
//   returns the address / remaining count after that burst is accepted.
// Ports:
//   cur_addr   in   next burst start byte address (8-byte aligned)
//   beats_left in   beats still to be requested
//   arlen      out  len-1 for the AR channel
//   next_addr  out  cur_addr + len*8
//   next_left  out  beats_left - len
module kan_burst_splitter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEFT_WIDTH = 24,
  parameter int MAX_BURST  = 16
) (
  input  logic [ADDR_WIDTH-1:0] cur_addr,
  input  logic [LEFT_WIDTH-1:0] beats_left,
  output logic [7:0]            arlen,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic [LEFT_WIDTH-1:0] next_left
);

  localparam logic [9:0] MAX_BURST_L = 10'(MAX_BURST);

  logic [9:0] beats_to_4k;
  logic [9:0] page_lim;
  logic [9:0] sel;
  logic [8:0] len;
  logic [8:0] len_m1;

  // Beat offset within the page is addr[11:3]; 512 beats per 4 KB page.
  assign beats_to_4k = 10'd512 - {1'b0, cur_addr[11:3]};

  // Min of the three limits; result never exceeds 256 so 9 bits suffice.
  always_comb begin
    page_lim = MAX_BURST_L;
    sel      = 10'd0;
    if (beats_to_4k < MAX_BURST_L) begin
      page_lim = beats_to_4k;
    end else begin
      page_lim = MAX_BURST_L;
    end
    if (beats_left < LEFT_WIDTH'(page_lim)) begin
      sel = beats_left[9:0];
    end else begin
      sel = page_lim;
    end
  end

  assign len       = sel[8:0];
  assign len_m1    = len - 9'd1;
  assign arlen     = len_m1[7:0];
  assign next_addr = cur_addr + ADDR_WIDTH'({len, 3'b000});
  assign next_left = beats_left - LEFT_WIDTH'(len);

endmodule

// File: rtl/kan_layer_sequencer.sv
// kan_layer_sequencer: steps KERNEL through a multi-layer KAN pass.
//   Holds a descriptor table written by the host, loads each layer's sizes
//   into KERNEL, issues the AR bursts for that layer's weights, and advances
//   once KERNEL's output stream signals the end of the layer.
// Ports:
//   s_axis_aclk / s_axis_areset   clock, async active-high reset
//   start, num_layers, busy, done  pass control / status
//   cfg_*                          descriptor table write (IDLE only)
//   m_axi_ar*                      AXI4 read-address master channel
//   m_axi_r{valid,ready,last}      R-channel taps for burst completion
//   m_axis_t{valid,ready,last}     KERNEL output taps for layer end
//   input_layersize_x5, output_layersize, layer_idx   to KERNEL
module kan_layer_sequencer
  import kan_pkg::*;
#(
  parameter int LG_LAYERSIZE    = 12,
  parameter int ADDR_WIDTH      = 32,
  parameter int LG_MAX_LAYERS   = 3,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_areset,
  input  logic                     start,
  input  logic [LG_MAX_LAYERS:0]   num_layers,
  output logic                     busy,
  output logic                     done,
  input  logic                     cfg_we,
  input  logic [LG_MAX_LAYERS-1:0] cfg_addr,
  input  logic [ADDR_WIDTH-1:0]    cfg_base,
  input  logic [LG_LAYERSIZE-1:0]  cfg_in_x5,
  input  logic [LG_LAYERSIZE-1:0]  cfg_out,
  output logic [ADDR_WIDTH-1:0]    m_axi_araddr,
  output logic [7:0]               m_axi_arlen,
  output logic [2:0]               m_axi_arsize,
  output logic [1:0]               m_axi_arburst,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic                     m_axi_rvalid,
  input  logic                     m_axi_rready,
  input  logic                     m_axi_rlast,
  input  logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  input  logic                     m_axis_tlast,
  output logic [LG_LAYERSIZE-1:0]  input_layersize_x5,
  output logic [LG_LAYERSIZE-1:0]  output_layersize,
  output logic [LG_MAX_LAYERS-1:0] layer_idx
);

  localparam int LEFT_W = 2 * LG_LAYERSIZE;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]         CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0]         CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LG_MAX_LAYERS:0]   IDX_ONE = {{LG_MAX_LAYERS{1'b0}}, 1'b1};
  localparam logic [LG_MAX_LAYERS-1:0] IDX_INC = {{(LG_MAX_LAYERS-1){1'b0}}, 1'b1};

  kan_desc_t desc_tab [2**LG_MAX_LAYERS];
  kan_desc_t cur_desc;

  kan_state_t state, state_n;
  logic                     busy_n, done_n, arvalid_n;
  logic [ADDR_WIDTH-1:0]    araddr_n, cur_addr, cur_addr_n;
  logic [7:0]               arlen_n;
  logic [LG_MAX_LAYERS-1:0] layer_idx_n;
  logic [LG_LAYERSIZE-1:0]  in_x5_n, out_n;
  logic [LEFT_W-1:0]        beats_left, beats_left_n, load_beats;
  logic [LG_MAX_LAYERS:0]   n_layers, n_layers_n;
  logic                     tlast_flag, tlast_flag_n;
  logic [CNT_W-1:0]         outstanding, cnt_n;

  logic [7:0]               split_arlen;
  logic [ADDR_WIDTH-1:0]    split_next_addr;
  logic [LEFT_W-1:0]        split_next_left;

  logic ar_hs, r_end, t_end;

  assign ar_hs = m_axi_arvalid & m_axi_arready;
  assign r_end = m_axi_rvalid & m_axi_rready & m_axi_rlast;
  assign t_end = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  assign m_axi_arsize  = ARSIZE_64B;
  assign m_axi_arburst = ARBURST_INCR;

  assign cur_desc   = desc_tab[layer_idx];
  assign load_beats = desc_beats(cur_desc);

  kan_burst_splitter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEFT_WIDTH (LEFT_W),
    .MAX_BURST  (MAX_BURST)
  ) u_splitter (
    .cur_addr   (cur_addr),
    .beats_left (beats_left),
    .arlen      (split_arlen),
    .next_addr  (split_next_addr),
    .next_left  (split_next_left)
  );

  // Descriptor table write port; the table has no reset.
  always_ff @(posedge s_axis_aclk) begin
    if (cfg_we && (state == ST_IDLE)) begin
      desc_tab[cfg_addr] <= '{base: cfg_base, in_x5: cfg_in_x5, out: cfg_out};
    end
  end

  // Outstanding-burst count: simultaneous issue and completion cancel out.
  always_comb begin
    cnt_n = outstanding;
    if (ar_hs && !r_end) begin
      cnt_n = outstanding + CNT_ONE;
    end else if (!ar_hs && r_end && (outstanding != '0)) begin
      cnt_n = outstanding - CNT_ONE;
    end else begin
      cnt_n = outstanding;
    end
  end

  // Next-state and next-output logic of the sequencer.
  always_comb begin
    state_n      = state;
    busy_n       = busy;
    done_n       = 1'b0;
    arvalid_n    = m_axi_arvalid;
    araddr_n     = m_axi_araddr;
    arlen_n      = m_axi_arlen;
    layer_idx_n  = layer_idx;
    in_x5_n      = input_layersize_x5;
    out_n        = output_layersize;
    cur_addr_n   = cur_addr;
    beats_left_n = beats_left;
    n_layers_n   = n_layers;
    tlast_flag_n = tlast_flag;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (num_layers != '0) begin
            state_n     = ST_LOAD;
            busy_n      = 1'b1;
            layer_idx_n = '0;
            n_layers_n  = num_layers;
          end else begin
            done_n = 1'b1;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOAD: begin
        in_x5_n      = cur_desc.in_x5;
        out_n        = cur_desc.out;
        cur_addr_n   = cur_desc.base;
        beats_left_n = load_beats;
        tlast_flag_n = 1'b0;
        if (load_beats == '0) begin
          state_n = ST_NEXT;
        end else begin
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (t_end) begin
          tlast_flag_n = 1'b1;
        end else begin
          tlast_flag_n = tlast_flag;
        end
        if (m_axi_arvalid) begin
          // Address and length stay frozen until the slave accepts.
          if (m_axi_arready) begin
            arvalid_n    = 1'b0;
            cur_addr_n   = split_next_addr;
            beats_left_n = split_next_left;
            if (split_next_left == '0) begin
              state_n = ST_DRAIN;
            end else begin
              state_n = ST_ISSUE;
            end
          end else begin
            arvalid_n = 1'b1;
          end
        end else if (outstanding < CNT_MAX) begin
          arvalid_n = 1'b1;
          araddr_n  = cur_addr;
          arlen_n   = split_arlen;
        end else begin
          arvalid_n = 1'b0;
        end
      end
      ST_DRAIN: begin
        // Layer ends on KERNEL's tlast (now or flagged earlier) once no
        // weight burst is still in flight.
        if ((t_end || tlast_flag) && (cnt_n == '0)) begin
          state_n      = ST_NEXT;
          tlast_flag_n = 1'b0;
        end else begin
          state_n = ST_DRAIN;
        end
      end
      ST_NEXT: begin
        if (({1'b0, layer_idx} + IDX_ONE) == n_layers) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
        end else begin
          layer_idx_n = layer_idx + IDX_INC;
          state_n     = ST_LOAD;
        end
      end
      default: begin
        state_n   = ST_IDLE;
        busy_n    = 1'b0;
        arvalid_n = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state              <= ST_IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      m_axi_arvalid      <= 1'b0;
      m_axi_araddr       <= '0;
      m_axi_arlen        <= 8'd0;
      layer_idx          <= '0;
      input_layersize_x5 <= '0;
      output_layersize   <= '0;
      cur_addr           <= '0;
      beats_left         <= '0;
      n_layers           <= '0;
      tlast_flag         <= 1'b0;
      outstanding        <= '0;
    end else begin
      state              <= state_n;
      busy               <= busy_n;
      done               <= done_n;
      m_axi_arvalid      <= arvalid_n;
      m_axi_araddr       <= araddr_n;
      m_axi_arlen        <= arlen_n;
      layer_idx          <= layer_idx_n;
      input_layersize_x5 <= in_x5_n;
      output_layersize   <= out_n;
      cur_addr           <= cur_addr_n;
      beats_left         <= beats_left_n;
      n_layers           <= n_layers_n;
      tlast_flag         <= tlast_flag_n;
      outstanding        <= cnt_n;
    end
  end

endmodule

// File: tb/tb_kan_layer_sequencer.sv
// tb_kan_layer_sequencer: scoreboard bench. Directed tests push expected AR
// bursts and done pulses into queues; a negedge monitor pops and compares.
module tb_kan_layer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, busy, done, cfg_we;
  logic [3:0]  num_layers;
  logic [2:0]  cfg_addr, layer_idx, arsize;
  logic [31:0] cfg_base, araddr;
  logic [11:0] cfg_in_x5, cfg_out, ix, osz;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arvalid, arready, rvalid, rready, rlast, tvalid, tready, tlast;

  kan_layer_sequencer dut (
    .s_axis_aclk (clk), .s_axis_areset (rst),
    .start (start), .num_layers (num_layers), .busy (busy), .done (done),
    .cfg_we (cfg_we), .cfg_addr (cfg_addr), .cfg_base (cfg_base),
    .cfg_in_x5 (cfg_in_x5), .cfg_out (cfg_out),
    .m_axi_araddr (araddr), .m_axi_arlen (arlen), .m_axi_arsize (arsize),
    .m_axi_arburst (arburst), .m_axi_arvalid (arvalid), .m_axi_arready (arready),
    .m_axi_rvalid (rvalid), .m_axi_rready (rready), .m_axi_rlast (rlast),
    .m_axis_tvalid (tvalid), .m_axis_tready (tready), .m_axis_tlast (tlast),
    .input_layersize_x5 (ix), .output_layersize (osz), .layer_idx (layer_idx)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  lidx;
    logic [11:0] ix;
    logic [11:0] osz;
  } ar_exp_t;

  ar_exp_t    ar_q[$];
  logic [2:0] done_q[$];
  ar_exp_t    mon_e;
  logic [2:0] mon_d;
  int compared = 0, mismatched = 0, pending_r = 0;
  bit auto_r = 1'b0, r_one = 1'b0, r_sync = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: event seen/expired, expected the opposite", name);
  endtask

  task automatic push_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] li,
                         input logic [11:0] x, input logic [11:0] o);
    ar_exp_t e;
    e.addr = a; e.len = l; e.lidx = li; e.ix = x; e.osz = o;
    ar_q.push_back(e);
  endtask

  // Monitor: every AR handshake and every done pulse is checked against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (arvalid && arready) begin
        pending_r++;
        chk("arsize", arsize, 3'b011);
        chk("arburst", arburst, 2'b01);
        if (ar_q.size() == 0) begin
          fail_now("unexpected_ar");
        end else begin
          mon_e = ar_q.pop_front();
          chk("araddr", araddr, mon_e.addr);
          chk("arlen", arlen, mon_e.len);
          chk("ar_layer_idx", layer_idx, mon_e.lidx);
          chk("ar_in_x5", ix, mon_e.ix);
          chk("ar_out", osz, mon_e.osz);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          mon_d = done_q.pop_front();
          chk("done_layer_idx", layer_idx, mon_d);
          chk("done_busy_low", busy, 1'b0);
        end
      end
    end
  end

  // R-channel model: one rlast handshake per accepted burst.
  always @(posedge clk) begin
    #1;
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    if (!rst && pending_r > 0) begin
      if (r_one) begin
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1; pending_r--;
        r_one = 1'b0; r_sync = 1'b1;
      end else if (r_sync && arvalid && arready) begin
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1; pending_r--;
        r_sync = 1'b0;
      end else if (auto_r) begin
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1; pending_r--;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cfg(input logic [2:0] a, input logic [31:0] b, input logic [11:0] x, input logic [11:0] o);
    cfg_we = 1'b1; cfg_addr = a; cfg_base = b; cfg_in_x5 = x; cfg_out = o;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic go(input logic [3:0] n);
    start = 1'b1; num_layers = n;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_issued();
    int t = 0;
    while ((ar_q.size() != 0 || pending_r != 0) && t < 500) begin tick(1); t++; end
    if (t >= 500) fail_now("wait_bursts_timeout");
    tick(2);
  endtask

  task automatic pulse_tlast();
    tvalid = 1'b1; tlast = 1'b1;
    tick(1);
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_q.size() != 0 && t < 200) begin tick(1); t++; end
    if (t >= 200) fail_now("wait_done_timeout");
    tick(1);
  endtask

  task automatic wait_arvalid();
    int t = 0;
    while (!arvalid && t < 20) begin tick(1); t++; end
    if (t >= 20) fail_now("wait_arvalid_timeout");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_layers = 4'd0; cfg_we = 1'b0; cfg_addr = 3'd0;
    cfg_base = 32'd0; cfg_in_x5 = 12'd0; cfg_out = 12'd0; arready = 1'b1;
    tvalid = 1'b0; tready = 1'b1; tlast = 1'b0;
    tick(2);
    chk("rst_busy", busy, 1'b0);       chk("rst_done", done, 1'b0);
    chk("rst_arvalid", arvalid, 1'b0); chk("rst_araddr", araddr, 32'd0);
    chk("rst_arlen", arlen, 8'd0);     chk("rst_layer_idx", layer_idx, 3'd0);
    chk("rst_in_x5", ix, 12'd0);       chk("rst_out", osz, 12'd0);
    rst = 1'b0;
    tick(1);

    // Single layer, 20 beats split 16 + 4.
    auto_r = 1'b1;
    cfg(3'd0, 32'h1000, 12'd5, 12'd4);
    push_ar(32'h1000, 8'd15, 3'd0, 12'd5, 12'd4);
    push_ar(32'h1080, 8'd3, 3'd0, 12'd5, 12'd4);
    go(4'd1);
    chk("busy_after_start", busy, 1'b1);
    wait_issued();
    done_q.push_back(3'd0);
    pulse_tlast();
    wait_done();
    chk("busy_after_done", busy, 1'b0);

    // 4 KB crossing, with cfg_we/start attempted while busy.
    cfg(3'd0, 32'h0FF0, 12'd5, 12'd2);
    for (int k = 0; k < 2; k++) begin
      push_ar(32'h0FF0, 8'd1, 3'd0, 12'd5, 12'd2);
      push_ar(32'h1000, 8'd7, 3'd0, 12'd5, 12'd2);
      go(4'd1);
      if (k == 0) begin
        cfg(3'd0, 32'h7000, 12'd1, 12'd1);
        go(4'd3);
      end
      wait_issued();
      done_q.push_back(3'd0);
      pulse_tlast();
      wait_done();
    end

    // Backpressure and outstanding limit: 96 beats = 6 bursts of 16.
    auto_r = 1'b0;
    arready = 1'b0;
    cfg(3'd0, 32'h2000, 12'd16, 12'd6);
    for (int k = 0; k < 6; k++) push_ar(32'h2000 + 32'(k) * 32'h80, 8'd15, 3'd0, 12'd16, 12'd6);
    go(4'd1);
    wait_arvalid();
    for (int k = 0; k < 5; k++) begin
      chk("stall_arvalid", arvalid, 1'b1);
      chk("stall_araddr", araddr, 32'h2000);
      chk("stall_arlen", arlen, 8'd15);
      tick(1);
    end
    arready = 1'b1;
    tick(12);
    chk("max_out_arvalid_low", arvalid, 1'b0);
    chk("max_out_bursts_left", ar_q.size(), 2);
    tick(3);
    chk("max_out_still_low", arvalid, 1'b0);
    r_one = 1'b1;
    tick(12);
    chk("simul_ar_rlast_bursts_left", ar_q.size(), 0);
    auto_r = 1'b1;
    wait_issued();
    done_q.push_back(3'd0);
    pulse_tlast();
    wait_done();

    // Three layers; sizes checked against each burst's layer.
    cfg(3'd0, 32'h3000, 12'd5, 12'd4);
    cfg(3'd1, 32'h4000, 12'd10, 12'd2);
    cfg(3'd2, 32'h5000, 12'd15, 12'd1);
    push_ar(32'h3000, 8'd15, 3'd0, 12'd5, 12'd4);
    push_ar(32'h3080, 8'd3, 3'd0, 12'd5, 12'd4);
    go(4'd3);
    wait_issued();
    chk("l0_in_x5_held", ix, 12'd5);
    push_ar(32'h4000, 8'd15, 3'd1, 12'd10, 12'd2);
    push_ar(32'h4080, 8'd3, 3'd1, 12'd10, 12'd2);
    pulse_tlast();
    wait_issued();
    chk("l1_out_held", osz, 12'd2);
    push_ar(32'h5000, 8'd14, 3'd2, 12'd15, 12'd1);
    pulse_tlast();
    wait_issued();
    done_q.push_back(3'd2);
    pulse_tlast();
    wait_done();
    chk("sizes_persist_in", ix, 12'd15);
    chk("sizes_persist_out", osz, 12'd1);

    // num_layers == 0, then a zero-size descriptor.
    done_q.push_back(3'd2);
    go(4'd0);
    wait_done();
    cfg(3'd0, 32'h6000, 12'd0, 12'd7);
    done_q.push_back(3'd0);
    go(4'd1);
    wait_done();
    chk("zero_size_in_x5", ix, 12'd0);
    chk("zero_size_out", osz, 12'd7);

    // Reset during ISSUE, then a clean pass.
    arready = 1'b0;
    cfg(3'd0, 32'h8000, 12'd16, 12'd16);
    go(4'd1);
    wait_arvalid();
    #2 rst = 1'b1;
    #1;
    chk("abort_arvalid", arvalid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    tick(2);
    pending_r = 0;
    rst = 1'b0;
    tick(1);
    arready = 1'b1;
    cfg(3'd0, 32'h1000, 12'd5, 12'd4);
    push_ar(32'h1000, 8'd15, 3'd0, 12'd5, 12'd4);
    push_ar(32'h1080, 8'd3, 3'd0, 12'd5, 12'd4);
    go(4'd1);
    wait_issued();
    done_q.push_back(3'd0);
    pulse_tlast();
    wait_done();
    chk("final_busy", busy, 1'b0);

    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
